// File: rtl/dma_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_arbiter_pkg
// Description : Shared state encoding and sizing helper for dma_arbiter.
// Revision    : 1.0
// ============================================================================
package dma_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    // Channel index width; never below one bit so ports stay legal.
    function automatic int ch_idx_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; first request at/after ptr.
// Revision    : 1.0
// ============================================================================
module rr_pick
    import dma_arbiter_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = ch_idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt_onehot,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              valid
);

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        valid      = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!valid && req[(int'(ptr) + i) % NUM_CH]) begin
                valid                                   = 1'b1;
                gnt_idx                                 = IDX_W'((int'(ptr) + i) % NUM_CH);
                gnt_onehot[(int'(ptr) + i) % NUM_CH]    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_arbiter
// Description : Round-robin arbiter sharing the dma_controller device port.
// Revision    : 1.0
// ============================================================================
module dma_arbiter
    import dma_arbiter_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int ADD_LEN  = 16,
    parameter int DATA_LEN = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_CH-1:0]               ch_enable,
    input  logic [NUM_CH-1:0]               ch_rqst,
    input  logic [NUM_CH-1:0]               ch_rd_wr,
    input  logic [NUM_CH*ADD_LEN-1:0]       ch_num_words,
    input  logic [NUM_CH*(ADD_LEN+1)-1:0]   ch_start_addr,
    input  logic [NUM_CH-1:0]               ch_dev_ack,
    input  logic [NUM_CH*DATA_LEN-1:0]      ch_dev_in,
    output logic [NUM_CH-1:0]               ch_grant,
    output logic [NUM_CH-1:0]               ch_dma_ack,
    output logic [NUM_CH-1:0]               ch_end_flag,
    output logic [DATA_LEN-1:0]             ch_dev_out,
    output logic                            busy,
    output logic [ch_idx_width(NUM_CH)-1:0] cur_ch,
    output logic                            rqst,
    output logic                            rd_wr,
    output logic [ADD_LEN-1:0]              num_words,
    output logic [ADD_LEN:0]                start_addr,
    output logic                            dev_ack,
    output logic [DATA_LEN-1:0]             dev_in,
    input  logic                            dma_ack,
    input  logic [DATA_LEN-1:0]             dev_out,
    input  logic                            end_flag
);

    localparam int c_IDX_W = ch_idx_width(NUM_CH);

    arb_state_t           r_state;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_IDX_W-1:0]   r_cur_ch;
    logic [NUM_CH-1:0]    r_grant;
    logic                 r_busy;
    logic                 r_rqst;
    logic                 r_rd_wr;
    logic [ADD_LEN-1:0]   r_num_words;
    logic [ADD_LEN:0]     r_start_addr;

    logic [NUM_CH-1:0]    w_pending;
    logic [NUM_CH-1:0]    w_pick_onehot;
    logic [c_IDX_W-1:0]   w_pick_idx;
    logic                 w_pick_valid;

    logic [ADD_LEN-1:0]   w_num_words  [NUM_CH];
    logic [ADD_LEN:0]     w_start_addr [NUM_CH];
    logic [DATA_LEN-1:0]  w_dev_in     [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
        assign w_num_words[c]  = ch_num_words[c*ADD_LEN +: ADD_LEN];
        assign w_start_addr[c] = ch_start_addr[c*(ADD_LEN+1) +: ADD_LEN+1];
        assign w_dev_in[c]     = ch_dev_in[c*DATA_LEN +: DATA_LEN];
    end

    assign w_pending = ch_rqst & ch_enable;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (c_IDX_W)
    ) u_rr_pick (
        .req        (w_pending),
        .ptr        (r_rr_ptr),
        .gnt_onehot (w_pick_onehot),
        .gnt_idx    (w_pick_idx),
        .valid      (w_pick_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_cur_ch     <= '0;
            r_grant      <= '0;
            r_busy       <= 1'b0;
            r_rqst       <= 1'b0;
            r_rd_wr      <= 1'b0;
            r_num_words  <= '0;
            r_start_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_cur_ch     <= w_pick_idx;
                        r_grant      <= w_pick_onehot;
                        r_rd_wr      <= ch_rd_wr[w_pick_idx];
                        r_num_words  <= w_num_words[w_pick_idx];
                        r_start_addr <= w_start_addr[w_pick_idx];
                        r_rqst       <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_rqst  <= 1'b0;
                    r_state <= ST_XFER;
                end
                // The DMA cannot abort, so only end_flag releases the grant.
                ST_XFER: begin
                    if (end_flag) begin
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    r_rr_ptr <= (r_cur_ch == c_IDX_W'(NUM_CH - 1)) ? '0
                                                                  : r_cur_ch + c_IDX_W'(1);
                    r_cur_ch <= '0;
                    r_grant  <= '0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dev_ack     = 1'b0;
        dev_in      = '0;
        ch_dma_ack  = '0;
        ch_end_flag = '0;
        if (r_state == ST_XFER) begin
            dev_ack               = ch_dev_ack[r_cur_ch];
            dev_in                = w_dev_in[r_cur_ch];
            ch_dma_ack[r_cur_ch]  = dma_ack;
            ch_end_flag[r_cur_ch] = end_flag;
        end
    end

    assign ch_dev_out = dev_out;
    assign ch_grant   = r_grant;
    assign busy       = r_busy;
    assign cur_ch     = r_cur_ch;
    assign rqst       = r_rqst;
    assign rd_wr      = r_rd_wr;
    assign num_words  = r_num_words;
    assign start_addr = r_start_addr;

endmodule
`default_nettype wire

// File: tb/tb_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_arbiter
// Description : Scoreboard bench for dma_arbiter with a small DMA model.
// Revision    : 1.0
// ============================================================================
module tb_dma_arbiter;

    localparam int NUM_CH = 4;
    localparam int AL     = 16;
    localparam int DL     = 16;

    logic                       clk = 1'b0;
    logic                       reset_n = 1'b0;
    logic [NUM_CH-1:0]          ch_enable = '0;
    logic [NUM_CH-1:0]          ch_rqst = '0;
    logic [NUM_CH-1:0]          ch_rd_wr = '0;
    logic [NUM_CH*AL-1:0]       ch_num_words = '0;
    logic [NUM_CH*(AL+1)-1:0]   ch_start_addr = '0;
    logic [NUM_CH-1:0]          ch_dev_ack = '0;
    logic [NUM_CH*DL-1:0]       ch_dev_in = '0;
    logic [NUM_CH-1:0]          ch_grant, ch_dma_ack, ch_end_flag;
    logic [DL-1:0]              ch_dev_out;
    logic                       busy, rqst, rd_wr, dev_ack;
    logic [1:0]                 cur_ch;
    logic [AL-1:0]              num_words;
    logic [AL:0]                start_addr;
    logic [DL-1:0]              dev_in;
    logic                       dma_ack = 1'b0;
    logic [DL-1:0]              dev_out = '0;
    logic                       end_flag = 1'b0;

    always #5 clk = ~clk;

    dma_arbiter #(.NUM_CH(NUM_CH), .ADD_LEN(AL), .DATA_LEN(DL)) dut (
        .clk(clk), .reset_n(reset_n), .ch_enable(ch_enable), .ch_rqst(ch_rqst),
        .ch_rd_wr(ch_rd_wr), .ch_num_words(ch_num_words), .ch_start_addr(ch_start_addr),
        .ch_dev_ack(ch_dev_ack), .ch_dev_in(ch_dev_in), .ch_grant(ch_grant),
        .ch_dma_ack(ch_dma_ack), .ch_end_flag(ch_end_flag), .ch_dev_out(ch_dev_out),
        .busy(busy), .cur_ch(cur_ch), .rqst(rqst), .rd_wr(rd_wr), .num_words(num_words),
        .start_addr(start_addr), .dev_ack(dev_ack), .dev_in(dev_in), .dma_ack(dma_ack),
        .dev_out(dev_out), .end_flag(end_flag)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, expv);
        end
    endtask

    typedef struct {
        int ch;
        bit rd;
        int n;
        int addr;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_exp(input int ch, input bit rd, input int n, input int addr);
        exp_t e;
        e.ch = ch; e.rd = rd; e.n = n; e.addr = addr;
        exp_q.push_back(e);
    endtask

    // Behavioural DMA: GET_REGS one cycle after rqst, zero-length ends at rqst+2.
    logic [15:0] mem [0:1023];
    int  d_state = 0, d_cnt = 0, d_n = 0, d_base = 0;
    bit  d_rd = 0;
    logic m_rqst, m_dev_ack, m_rd;
    logic [DL-1:0] m_dev_in;
    logic [AL-1:0] m_nw;
    logic [AL:0]   m_sa;

    initial begin
        forever begin
            @(negedge clk);
            m_rqst = rqst; m_dev_ack = dev_ack; m_dev_in = dev_in;
            m_nw = num_words; m_sa = start_addr; m_rd = rd_wr;
            @(posedge clk);
            #1;
            if (!reset_n) begin
                d_state = 0; dma_ack = 1'b0; end_flag = 1'b0;
            end else begin
                case (d_state)
                    0: if (m_rqst) d_state = 1;
                    1: begin
                        d_n = int'(m_nw); d_rd = m_rd; d_base = int'(m_sa[10:1]); d_cnt = 0;
                        if (d_n == 0) begin end_flag = 1'b1; d_state = 3; end
                        else d_state = 2;
                    end
                    2: begin
                        if (d_cnt < d_n && (d_rd || m_dev_ack)) begin
                            if (d_rd) dev_out = 16'(32'hD000 + d_cnt);
                            else      mem[d_base + d_cnt] = m_dev_in;
                            dma_ack = 1'b1;
                            d_cnt++;
                        end else if (d_cnt == d_n) begin
                            dma_ack = 1'b0; end_flag = 1'b1; d_state = 3;
                        end else begin
                            dma_ack = 1'b0;
                        end
                    end
                    default: begin end_flag = 1'b0; d_state = 0; end
                endcase
            end
        end
    end

    // Monitor: pops an expectation on every rqst and scores the transfer.
    int   cyc = 0, active = -1, ack_cnt = 0, rq_cyc = 0, done_cnt = 0;
    exp_t cur;
    always @(posedge clk) cyc++;

    initial begin
        cur.ch = 0; cur.rd = 0; cur.n = 0; cur.addr = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                active = -1;
            end else begin
                if (rqst) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rqst", rqst, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("grant_ch", cur_ch, cur.ch);
                        chk("grant_onehot", ch_grant, 1 << cur.ch);
                        chk("desc_rd_wr", rd_wr, cur.rd);
                        chk("desc_num_words", num_words, cur.n);
                        chk("desc_start_addr", start_addr, cur.addr);
                        active = cur.ch; ack_cnt = 0; rq_cyc = cyc;
                    end
                end
                if (ch_dma_ack != 0) begin
                    chk("dma_ack_route", ch_dma_ack, (active >= 0) ? (1 << active) : 0);
                    if (active >= 0 && ch_dma_ack[active]) begin
                        ack_cnt++;
                        if (cur.rd) chk("read_data", ch_dev_out, 32'hD000 + ack_cnt - 1);
                    end
                end
                if (dev_ack) begin
                    if (active >= 0) chk("dev_in_route", dev_in, ch_dev_in[active*DL +: DL]);
                    else             chk("dev_ack_idle", dev_ack, 0);
                end
                if (ch_end_flag != 0) begin
                    chk("end_route", ch_end_flag, (active >= 0) ? (1 << active) : 0);
                    if (active >= 0) begin
                        chk("ack_count", ack_cnt, cur.n);
                        if (cur.n == 0)  chk("zero_len_latency", cyc - rq_cyc, 2);
                        else if (cur.rd) chk("read_latency", cyc - rq_cyc, cur.n + 3);
                    end
                    done_cnt++;
                    active = -1;
                end
            end
        end
    end

    // Device-side behaviour: drop request after end (or re-request), write stalls.
    int rereq [NUM_CH];
    bit wr_mode = 0;
    int wr_phase = -1, wr_idx = 0;
    logic [NUM_CH-1:0] s_end, s_grant, s_pend;
    logic s_busy, s_ack0;

    task automatic step();
        @(negedge clk);
        s_end = ch_end_flag; s_grant = ch_grant; s_busy = busy;
        s_pend = ch_rqst & ch_enable; s_ack0 = ch_dma_ack[0];
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (s_end[c]) begin
                if (rereq[c] > 0) rereq[c]--;
                else ch_rqst[c] = 1'b0;
            end
        end
        if (wr_mode) begin
            if (s_ack0) wr_idx++;
            if (wr_phase < 0 && s_grant[0]) wr_phase = 0;
            if (wr_phase >= 0) begin
                ch_dev_ack[0] = (wr_phase % 3 == 2);
                wr_phase++;
            end
            ch_dev_in[DL-1:0] = 16'(32'hA000 + wr_idx);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(s_busy == 1'b0 && s_pend == '0) && n < 400);
        if (n >= 400) chk(name, {s_busy, s_pend}, 0);
    endtask

    task automatic set_desc(input int c, input bit rd, input int n, input int addr);
        ch_rd_wr[c]                    = rd;
        ch_num_words[c*AL +: AL]       = AL'(n);
        ch_start_addr[c*(AL+1) +: AL+1] = (AL+1)'(addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < NUM_CH; c++) rereq[c] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", ch_grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rqst", rqst, 0);
        chk("rst_cur_ch", cur_ch, 0);
        chk("rst_num_words", num_words, 0);
        chk("rst_start_addr", start_addr, 0);
        chk("rst_routed", {dev_ack, dev_in, ch_dma_ack, ch_end_flag}, 0);
        reset_n   = 1'b1;
        ch_enable = '1;
        step();

        // Single read on ch1; afterwards rr_ptr should be 2.
        set_desc(1, 1, 4, 'h0200);
        push_exp(1, 1, 4, 'h0200);
        ch_rqst[1] = 1'b1;
        wait_idle("single_read_timeout");

        // ch0 and ch2 together: rr_ptr=2 puts ch2 first.
        set_desc(0, 1, 1, 'h0050);
        set_desc(2, 1, 2, 'h0060);
        push_exp(2, 1, 2, 'h0060);
        push_exp(0, 1, 1, 'h0050);
        ch_rqst[0] = 1'b1; ch_rqst[2] = 1'b1;
        wait_idle("rr_ptr_timeout");

        // Zero-length write on ch3 (rr_ptr=1 -> 0 afterwards).
        set_desc(3, 0, 0, 'h0080);
        push_exp(3, 0, 0, 'h0080);
        ch_rqst[3] = 1'b1;
        wait_idle("zero_len_timeout");

        // Contention from rr_ptr=0 with ch0 re-requesting.
        set_desc(0, 1, 1, 'h0010);
        set_desc(2, 1, 2, 'h0020);
        set_desc(3, 1, 1, 'h0030);
        push_exp(0, 1, 1, 'h0010);
        push_exp(2, 1, 2, 'h0020);
        push_exp(3, 1, 1, 'h0030);
        push_exp(0, 1, 1, 'h0010);
        rereq[0] = 1;
        ch_rqst = 4'b1101;
        wait_idle("contention_timeout");

        // Masked ch2 stays ungranted until enabled.
        set_desc(2, 1, 1, 'h0040);
        ch_enable[2] = 1'b0;
        ch_rqst[2]   = 1'b1;
        repeat (6) step();
        chk("mask_busy", s_busy, 0);
        chk("mask_grant", s_grant, 0);
        push_exp(2, 1, 1, 'h0040);
        ch_enable[2] = 1'b1;
        step();
        step();
        chk("mask_grant_latency", s_grant, 4'b0100);
        wait_idle("mask_timeout");

        // ch0 write of 6 words with stalls; ch1 drives junk handshakes.
        set_desc(0, 0, 6, 'h0400);
        push_exp(0, 0, 6, 'h0400);
        ch_dev_ack[1]      = 1'b1;
        ch_dev_in[DL +: DL] = 16'hBAD0;
        wr_mode = 1; wr_phase = -1; wr_idx = 0;
        ch_dev_in[DL-1:0] = 16'hA000;
        ch_rqst[0] = 1'b1;
        wait_idle("write_timeout");
        wr_mode = 0;
        ch_dev_ack = '0;
        for (int i = 0; i < 6; i++) chk("write_mem", mem['h200 + i], 32'hA000 + i);

        // Reset in the middle of a ch1 read, then a clean re-grant.
        set_desc(1, 1, 8, 'h0300);
        push_exp(1, 1, 8, 'h0300);
        ch_rqst[1] = 1'b1;
        begin
            int n;
            n = 0;
            while (!(active == 1 && ack_cnt >= 3) && n < 100) begin
                step();
                n++;
            end
            if (n >= 100) chk("reset_setup_timeout", ack_cnt, 3);
        end
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_grant", ch_grant, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_rqst", rqst, 0);
        chk("async_rst_routed", {dev_ack, ch_dma_ack, ch_end_flag}, 0);
        repeat (2) step();
        set_desc(1, 1, 2, 'h0310);
        push_exp(1, 1, 2, 'h0310);
        reset_n = 1'b1;
        wait_idle("post_reset_timeout");

        chk("queue_empty", exp_q.size(), 0);
        chk("done_count", done_cnt, 11);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
